bbox_draw: RTL and testbench
============================

# bbox_draw

Renders a rectangle outline into the 100×100 image RAM from four bounding-box coordinates. It is the writer counterpart to `boundingBoxTop`, which reads an image and extracts `xMin/yMin/xMax/yMax`. `bbox_draw` takes those coordinates and emits one RAM write per cycle to draw the box, optionally clearing the frame first. Its output port connects directly to the write side of the same single-port image RAM. A box drawn by it and then scanned by `boundingBoxTop` returns identical coordinates.

## Interface
- `WIDTH`, 100: image width in pixels.
- `HEIGHT`, 100: image height in pixels.
- `COORD_W`, 7: coordinate width.
- `ADDR_W`, 14: RAM address width.
- `DATA_W`, 8: pixel width.
- `FG`, 8'hFF: outline pixel value.
- `BG`, 8'h00: clear value.
- `CLOCK_50`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a draw; sampled only in IDLE.
- `clear`  in  1  sampled with `start`; 1 = fill the whole frame with `BG` before drawing.
- `xMin`, `yMin`, `xMax`, `yMax`  in  COORD_W each  box corners, inclusive; latched when `start` is sampled.
- `busy`  out  1  high from the cycle after `start` is accepted until `done` rises.
- `done`  out  1  level; held until the next accepted `start`.
- `err`  out  1  invalid coordinates on the last start; valid while `done`=1.
- `wr_en`  out  1  write strobe, registered.
- `wr_addr`  out  ADDR_W  pixel address = y*WIDTH + x, registered.
- `wr_data`  out  DATA_W  pixel value, registered.

## Operation
- FSM states: IDLE, CLEAR, TOP, BOTTOM, SIDES, DONE.
- In IDLE or DONE, `start`=1 latches the coordinates and `clear`, deasserts `done` and `err`, and branches as follows:
  - invalid coordinates (`xMin>xMax`, `yMin>yMax`, `xMax>=WIDTH`, or `yMax>=HEIGHT`) -> DONE with `err`=1, no writes;
  - else if `clear`=1 -> CLEAR;
  - else -> TOP.
- CLEAR writes `BG` to addresses 0..WIDTH*HEIGHT-1, ascending, then -> TOP.
- TOP writes `FG` at (x, yMin) for x = xMin..xMax, ascending.
- BOTTOM writes (x, yMax) for x = xMin..xMax. It is skipped when `yMax==yMin`.
- SIDES handles each row y = yMin+1..yMax-1, ascending:
  - write (xMin, y);
  - then write (xMax, y), skipped when `xMax==xMin`.
  - The whole state is skipped when `yMax-yMin<2`.
- Every outline pixel is written exactly once. With w = xMax-xMin+1 and h = yMax-yMin+1, the outline write count N is:
  - w if h=1;
  - h if w=1;
  - 2w + 2(h-2) otherwise.
- Addresses are generated incrementally: a row base is stepped by WIDTH, with no multiplier. `wr_addr` never exceeds WIDTH*HEIGHT-1.
- `start` while `busy` is ignored. Input coordinate changes after the latch have no effect.
- Reset values: state IDLE; `busy`, `done`, `err`, `wr_en` = 0; `wr_addr`, `wr_data` = 0.
- Reset asserted mid-draw forces the reset values immediately (asynchronously). A partially drawn image remains in RAM and is not repaired.

## Timing
- `start` is sampled at edge E. The first write (`wr_en`=1) is presented in the cycle after E.
- Writes are back-to-back with no gaps, including across CLEAR->TOP->BOTTOM->SIDES transitions.
- Total writes per draw: N, plus WIDTH*HEIGHT when `clear`=1.
- `done` rises in the cycle immediately after the last `wr_en` cycle, and `busy` falls in that same cycle.
- Invalid coordinates: `done`=1 and `err`=1 in the cycle after E, and `wr_en` is never asserted.
- `start` in DONE restarts with the same latency as from IDLE, so `done` drops in the cycle after E.
- RAM write latency is the RAM's own. The block does not read back.

## Test plan
- Square (28,29,79,65), `clear`=0 -> 174 writes. First write addr 2928, then 2929; TOP ends at 2979; BOTTOM spans 6528..6579; last write is 6479. `done` high the next cycle; `err`=0.
- Single pixel (99,99,99,99) -> exactly one write to addr 9999; `done` high 2 cycles after the start edge.
- (0,0,0,0) with `clear`=1 -> 10000 `BG` writes to addrs 0..9999, then one `FG` write to addr 0, for 10001 contiguous writes.
- Invalid (50,10,10,20) -> zero writes; `done`=1 and `err`=1 one cycle after start. A following valid start clears `err`.
- Assert `rst` during TOP of the square case -> `wr_en`, `busy`, `done` go to 0 at once. A new start after release produces the full 174-write sequence.
- Round trip: (27,27,81,78) with `clear`=1 drawn into the RAM, then `boundingBoxTop` run on it -> reports 27 27 81 78.

Source files
------------

// File: rtl/bbox_draw.sv
// bbox_draw: draws a rectangle outline into the image RAM, one registered write per cycle,
// optionally clearing the whole frame to BG first.
module bbox_draw #(
    parameter int WIDTH   = 100,
    parameter int HEIGHT  = 100,
    parameter int COORD_W = 7,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter logic [DATA_W-1:0] FG = 8'hFF,
    parameter logic [DATA_W-1:0] BG = 8'h00
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    input  logic               start,
    input  logic               clear,
    input  logic [COORD_W-1:0] xMin,
    input  logic [COORD_W-1:0] yMin,
    input  logic [COORD_W-1:0] xMax,
    input  logic [COORD_W-1:0] yMax,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data
);
    typedef enum logic [2:0] {IDLE, CLEAR, TOP, BOTTOM, SIDES, DONE} state_t;

    localparam logic [ADDR_W-1:0]  LAST = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0]  STEP = ADDR_W'(WIDTH);
    localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

    // Shift-and-add row base so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] row_base(input logic [COORD_W-1:0] y);
        row_base = '0;
        for (int i = 0; i < COORD_W; i++)
            if (y[i]) row_base = row_base + (STEP << i);
    endfunction

    state_t st_q, st_d;
    logic [COORD_W-1:0] xmin_q, ymin_q, xmax_q, ymax_q;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0]  base_q, base_d, top_q, btm_q, addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic side_q, side_d, done_q, done_d, err_q, err_d, wr_en_q, wr_en_d;
    logic lat, bad;

    assign bad = (xMin > xMax) || (yMin > yMax) || (int'(xMax) >= WIDTH) || (int'(yMax) >= HEIGHT);

    always_comb begin
        st_d    = st_q;
        x_d     = x_q;
        y_d     = y_q;
        side_d  = side_q;
        base_d  = base_q;
        done_d  = done_q;
        err_d   = err_q;
        wr_en_d = 1'b0;
        lat     = 1'b0;
        case (st_q)
            IDLE, DONE: if (start) begin
                lat    = 1'b1;
                done_d = bad;
                err_d  = bad;
                if (bad) st_d = DONE;
                else begin
                    wr_en_d = 1'b1;
                    st_d    = clear ? CLEAR : TOP;
                    x_d     = xMin;
                    base_d  = row_base(yMin);
                end
            end
            CLEAR: begin
                wr_en_d = 1'b1;
                if (addr_q == LAST) begin
                    st_d   = TOP;
                    x_d    = xmin_q;
                    base_d = top_q;
                end
            end
            TOP: begin
                if (x_q != xmax_q) begin
                    wr_en_d = 1'b1;
                    x_d     = x_q + ONE;
                end else if (ymax_q != ymin_q) begin
                    wr_en_d = 1'b1;
                    st_d    = BOTTOM;
                    x_d     = xmin_q;
                    base_d  = btm_q;
                end else begin
                    st_d   = DONE;
                    done_d = 1'b1;
                end
            end
            BOTTOM: begin
                if (x_q != xmax_q) begin
                    wr_en_d = 1'b1;
                    x_d     = x_q + ONE;
                end else if ((ymax_q - ymin_q) > ONE) begin
                    wr_en_d = 1'b1;
                    st_d    = SIDES;
                    y_d     = ymin_q + ONE;
                    base_d  = top_q + STEP;
                    x_d     = xmin_q;
                    side_d  = 1'b0;
                end else begin
                    st_d   = DONE;
                    done_d = 1'b1;
                end
            end
            SIDES: begin
                if (!side_q && xmax_q != xmin_q) begin
                    wr_en_d = 1'b1;
                    side_d  = 1'b1;
                    x_d     = xmax_q;
                end else if (y_q + ONE != ymax_q) begin
                    wr_en_d = 1'b1;
                    y_d     = y_q + ONE;
                    base_d  = base_q + STEP;
                    x_d     = xmin_q;
                    side_d  = 1'b0;
                end else begin
                    st_d   = DONE;
                    done_d = 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
        addr_d = !wr_en_d ? addr_q :
                 (st_d == CLEAR) ? ((st_q == CLEAR) ? addr_q + ADDR_W'(1) : '0) :
                 base_d + ADDR_W'(x_d);
        data_d = !wr_en_d ? data_q : (st_d == CLEAR) ? BG : FG;
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            st_q    <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            side_q  <= 1'b0;
            base_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            xmin_q  <= '0;
            ymin_q  <= '0;
            xmax_q  <= '0;
            ymax_q  <= '0;
            top_q   <= '0;
            btm_q   <= '0;
        end else begin
            st_q    <= st_d;
            x_q     <= x_d;
            y_q     <= y_d;
            side_q  <= side_d;
            base_q  <= base_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            if (lat) begin
                xmin_q <= xMin;
                ymin_q <= yMin;
                xmax_q <= xMax;
                ymax_q <= yMax;
                top_q  <= row_base(yMin);
                btm_q  <= row_base(yMax);
            end
        end
    end

    // Every non-idle cycle of a valid draw is a write, so busy tracks the strobe.
    assign busy    = wr_en_q;
    assign done    = done_q;
    assign err     = err_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = addr_q;
    assign wr_data = data_q;
endmodule

// File: tb/tb_bbox_draw.sv
// tb_bbox_draw: directed checks of bbox_draw write sequences, timing, errors and reset.
module tb_bbox_draw;
    logic CLOCK_50 = 1'b0, rst = 1'b1, start = 1'b0, clear = 1'b0;
    logic [6:0] xMin = '0, yMin = '0, xMax = '0, yMax = '0;
    logic busy, done, err, wr_en;
    logic [13:0] wr_addr;
    logic [7:0] wr_data;

    bbox_draw dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .start(start), .clear(clear),
        .xMin(xMin), .yMin(yMin), .xMax(xMax), .yMax(yMax),
        .busy(busy), .done(done), .err(err), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int vectors = 0, miscompares = 0;
    logic [13:0] wa[$];
    logic [7:0]  wd[$];
    int first_cyc, done_cyc;
    bit gap, tmo;
    logic err_seen;
    logic [7:0] ram [0:9999];

    always @(posedge CLOCK_50)
        if (wr_en && wr_addr < 14'd10000) ram[wr_addr] <= wr_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] wat(input int i);
        return (i < wa.size()) ? wa[i] : 14'h3fff;
    endfunction

    task automatic launch(input int x0, input int y0, input int x1, input int y1, input logic clr);
        @(negedge CLOCK_50);
        xMin = 7'(x0); yMin = 7'(y0); xMax = 7'(x1); yMax = 7'(y1); clear = clr; start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
    endtask

    // Samples one cycle at a time from the cycle after the start edge until done.
    task automatic collect(input bit noise);
        wa.delete(); wd.delete();
        first_cyc = 0; done_cyc = 0; gap = 0; tmo = 0; err_seen = 1'bx;
        if (noise) begin
            start = 1'b1; clear = 1'b1; xMin = 7'd3; yMin = 7'd4; xMax = 7'd5; yMax = 7'd6;
        end
        for (int c = 1; c <= 12000; c++) begin
            if (c > 1) begin @(posedge CLOCK_50); #1; end
            if (done) begin done_cyc = c; err_seen = err; break; end
            if (wr_en) begin
                if (first_cyc == 0) first_cyc = c;
                wa.push_back(wr_addr);
                wd.push_back(wr_data);
            end else if (wa.size() > 0) gap = 1;
        end
        start = 1'b0;
        if (done_cyc == 0) tmo = 1;
    endtask

    task automatic verify(input string tag, input int x0, input int y0, input int x1, input int y1, input bit clr);
        logic [13:0] ea[$];
        logic [7:0]  ed[$];
        int bad_cnt = 0;
        if (clr) for (int a = 0; a < 10000; a++) begin ea.push_back(14'(a)); ed.push_back(8'h00); end
        for (int x = x0; x <= x1; x++) begin ea.push_back(14'(y0 * 100 + x)); ed.push_back(8'hFF); end
        if (y1 != y0)
            for (int x = x0; x <= x1; x++) begin ea.push_back(14'(y1 * 100 + x)); ed.push_back(8'hFF); end
        for (int y = y0 + 1; y < y1; y++) begin
            ea.push_back(14'(y * 100 + x0)); ed.push_back(8'hFF);
            if (x1 != x0) begin ea.push_back(14'(y * 100 + x1)); ed.push_back(8'hFF); end
        end
        chk({tag, " timeout"}, tmo, 0);
        chk({tag, " count"}, wa.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa.size(); i++)
            if (wa[i] !== ea[i] || wd[i] !== ed[i]) bad_cnt++;
        chk({tag, " seq errors"}, bad_cnt, 0);
        chk({tag, " first write cycle"}, first_cyc, 1);
        chk({tag, " done cycle"}, done_cyc, ea.size() + 1);
        chk({tag, " gap"}, gap, 0);
        chk({tag, " err"}, err_seen, 0);
        chk({tag, " busy at done"}, busy, 0);
    endtask

    initial begin
        int mnx, mny, mxx, mxy, stray;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst wr_en", wr_en, 0);
        chk("rst wr_addr", wr_addr, 0);
        chk("rst wr_data", wr_data, 0);
        @(negedge CLOCK_50) rst = 1'b0;

        launch(28, 29, 79, 65, 1'b0); collect(1'b0);
        verify("square", 28, 29, 79, 65, 1'b0);
        chk("square n", wa.size(), 174);
        chk("square w0", wat(0), 2928);
        chk("square w1", wat(1), 2929);
        chk("square top end", wat(51), 2979);
        chk("square bottom start", wat(52), 6528);
        chk("square bottom end", wat(103), 6579);
        chk("square last", wat(173), 6479);

        launch(28, 29, 79, 65, 1'b0); collect(1'b1);
        verify("square noisy inputs", 28, 29, 79, 65, 1'b0);

        launch(99, 99, 99, 99, 1'b0); collect(1'b0);
        verify("pixel", 99, 99, 99, 99, 1'b0);
        chk("pixel addr", wat(0), 9999);
        chk("pixel done cycle", done_cyc, 2);

        launch(5, 10, 5, 14, 1'b0); collect(1'b0);
        verify("column", 5, 10, 5, 14, 1'b0);
        launch(10, 20, 15, 21, 1'b0); collect(1'b0);
        verify("two rows", 10, 20, 15, 21, 1'b0);

        launch(0, 0, 0, 0, 1'b1); collect(1'b0);
        verify("clear origin", 0, 0, 0, 0, 1'b1);
        chk("clear origin n", wa.size(), 10001);

        launch(50, 10, 10, 20, 1'b0);
        chk("invalid done", done, 1);
        chk("invalid err", err, 1);
        chk("invalid busy", busy, 0);
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            if (wr_en) stray++;
            @(posedge CLOCK_50); #1;
        end
        chk("invalid writes", stray, 0);
        chk("invalid done held", done, 1);
        launch(1, 2, 3, 4, 1'b0);
        chk("restart done low", done, 0);
        chk("restart err low", err, 0);
        collect(1'b0);
        verify("after invalid", 1, 2, 3, 4, 1'b0);
        launch(0, 0, 100, 5, 1'b0);
        chk("xmax range err", err, 1);
        chk("xmax range wr_en", wr_en, 0);

        launch(28, 29, 79, 65, 1'b0);
        repeat (20) @(posedge CLOCK_50);
        #1;
        chk("mid draw wr_en", wr_en, 1);
        rst = 1'b1;
        #1;
        chk("async rst wr_en", wr_en, 0);
        chk("async rst busy", busy, 0);
        chk("async rst done", done, 0);
        @(negedge CLOCK_50) rst = 1'b0;
        launch(28, 29, 79, 65, 1'b0); collect(1'b0);
        verify("square after rst", 28, 29, 79, 65, 1'b0);

        launch(27, 27, 81, 78, 1'b1); collect(1'b0);
        verify("round trip", 27, 27, 81, 78, 1'b1);
        mnx = 999; mny = 999; mxx = -1; mxy = -1;
        for (int y = 0; y < 100; y++)
            for (int x = 0; x < 100; x++)
                if (ram[y * 100 + x] === 8'hFF) begin
                    if (x < mnx) mnx = x;
                    if (y < mny) mny = y;
                    if (x > mxx) mxx = x;
                    if (y > mxy) mxy = y;
                end
        chk("scan xMin", mnx, 27);
        chk("scan yMin", mny, 27);
        chk("scan xMax", mxx, 81);
        chk("scan yMax", mxy, 78);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
